// File: rtl/isqrt_iterative_pkg.sv
// -----------------------------------------------------------------------------
// isqrt_iterative_pkg
// Shared constants for the iterative integer square root block: FSM state
// encodings (kept as plain 2-bit constants for compatibility with existing
// users of the legacy encoding) and a helper to size the step counter.
// -----------------------------------------------------------------------------
package isqrt_iterative_pkg;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  // Bits needed to hold a step count running from root_w down to 0.
  function automatic int unsigned cnt_width(input int unsigned root_w);
    return $clog2(root_w + 1);
  endfunction

endpackage

// File: rtl/isqrt_iterative_step.sv
// -----------------------------------------------------------------------------
// isqrt_step
// One digit of the restoring (digit-by-digit) square root. Purely
// combinational: brings down the next two operand bits into the partial
// remainder, trial-subtracts (root << 2) | 1 and produces the next partial
// remainder and the partial root extended by one result bit.
//
// Ports:
//   rem_i   [ROOT_W+1:0]  partial remainder from the previous step
//   root_i  [ROOT_W-1:0]  partial root from the previous step
//   bits_i  [1:0]         next two operand bits (MSB first)
//   rem_o   [ROOT_W+1:0]  next partial remainder
//   root_o  [ROOT_W-1:0]  next partial root
// -----------------------------------------------------------------------------
module isqrt_step
  import isqrt_iterative_pkg::*;
#(
  parameter int unsigned ROOT_W = 4
) (
  input  logic [ROOT_W+1:0] rem_i,
  input  logic [ROOT_W-1:0] root_i,
  input  logic [1:0]        bits_i,
  output logic [ROOT_W+1:0] rem_o,
  output logic [ROOT_W-1:0] root_o
);

  localparam int unsigned IREM_W = ROOT_W + 2;

  logic [IREM_W-1:0] r;
  logic [IREM_W-1:0] t;
  logic              ge;

  // The partial remainder never exceeds 2*root, so the two bits dropped by
  // the truncating shift are always zero; likewise the partial root MSB is
  // zero on every step except after the last one.
  always_comb begin
    r      = IREM_W'({rem_i, bits_i});
    t      = {root_i, 2'b01};
    ge     = (r >= t);
    rem_o  = ge ? (r - t) : r;
    root_o = ROOT_W'({root_i, ge});
  end

endmodule

// File: rtl/isqrt_iterative.sv
// -----------------------------------------------------------------------------
// isqrt_iterative
// Sequential unsigned integer square root. Accepts a WIDTH-bit operand over a
// valid/ready handshake, resolves one root bit per clock, and returns the
// floor root and remainder over a second valid/ready handshake.
//
// Ports:
//   clk        clock, all state on rising edge
//   rst        synchronous active-high reset
//   in_valid   operand present
//   in_ready   block idle; operand taken when in_valid && in_ready
//   in         [WIDTH-1:0]   unsigned operand
//   out_valid  root/remainder valid
//   out_ready  consumer takes the result
//   root       [WIDTH/2-1:0] floor(sqrt(in))
//   remainder  [WIDTH/2:0]   in - root*root
// -----------------------------------------------------------------------------
module isqrt_iterative
  import isqrt_iterative_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH/2-1:0] root,
  output logic [WIDTH/2:0]   remainder
);

  localparam int unsigned ROOT_W = WIDTH / 2;
  localparam int unsigned REM_W  = ROOT_W + 1;
  localparam int unsigned IREM_W = ROOT_W + 2;
  localparam int unsigned CNT_W  = cnt_width(ROOT_W);
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(ROOT_W);

  logic [1:0]        state_q, state_d;
  logic [WIDTH-1:0]  opnd_q,  opnd_d;
  logic [IREM_W-1:0] prem_q,  prem_d;
  logic [ROOT_W-1:0] proot_q, proot_d;
  logic [CNT_W-1:0]  cnt_q,   cnt_d;
  logic [ROOT_W-1:0] root_q,  root_d;
  logic [REM_W-1:0]  rem_q,   rem_d;

  logic [IREM_W-1:0] step_rem;
  logic [ROOT_W-1:0] step_root;

  isqrt_step #(
    .ROOT_W (ROOT_W)
  ) u_step (
    .rem_i  (prem_q),
    .root_i (proot_q),
    .bits_i (opnd_q[WIDTH-1 -: 2]),
    .rem_o  (step_rem),
    .root_o (step_root)
  );

  always_comb begin
    state_d = state_q;
    opnd_d  = opnd_q;
    prem_d  = prem_q;
    proot_d = proot_q;
    cnt_d   = cnt_q;
    root_d  = root_q;
    rem_d   = rem_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          state_d = S_CALC;
          opnd_d  = in;
          prem_d  = '0;
          proot_d = '0;
          cnt_d   = CNT_INIT;
        end
      end
      S_CALC: begin
        opnd_d  = opnd_q << 2;
        prem_d  = step_rem;
        proot_d = step_root;
        cnt_d   = cnt_q - CNT_W'(1);
        // Results are captured straight from the last step so the visible
        // outputs only ever change on the CALC->DONE edge.
        if (cnt_q == CNT_W'(1)) begin
          state_d = S_DONE;
          root_d  = step_root;
          rem_d   = REM_W'(step_rem);
        end
      end
      S_DONE: begin
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      opnd_q  <= '0;
      prem_q  <= '0;
      proot_q <= '0;
      cnt_q   <= '0;
      root_q  <= '0;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      opnd_q  <= opnd_d;
      prem_q  <= prem_d;
      proot_q <= proot_d;
      cnt_q   <= cnt_d;
      root_q  <= root_d;
      rem_q   <= rem_d;
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign root      = root_q;
  assign remainder = rem_q;

endmodule
